// File: rtl/fmcw_pkg.sv
// Shared FMCW front-end definitions: default sample/filter geometry and the chirp scheduler state encoding.
package fmcw_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_OUT_W   = 28;
    localparam int DEF_TAPS    = 16;
    localparam int DEF_N_SAMP  = 256;
    localparam int DEF_N_CHIRP = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CHIRP,
        ST_RUN,
        ST_DRAIN,
        ST_ABORT
    } state_t;

endpackage

// File: rtl/fir_chirp_scheduler.sv
// Feeds one chirp of ADC samples plus a TAPS-1 zero flush into an external FIR and forwards its steady-state results.
// All outputs registered (1-cycle latency); no backpressure -- samples arriving outside RUN are dropped and flagged.
module fir_chirp_scheduler
    import fmcw_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int TAPS    = DEF_TAPS,
    parameter int N_SAMP  = DEF_N_SAMP,
    parameter int N_CHIRP = DEF_N_CHIRP
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       chirp_start,
    input  logic                       adc_valid,
    input  logic [DATA_W-1:0]          adc_data,
    output logic                       fir_ready,
    output logic [DATA_W-1:0]          fir_mix_data,
    input  logic                       fir_valid,
    input  logic [OUT_W-1:0]           fir_data,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [$clog2(N_CHIRP)-1:0] chirp_idx,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int CI_W  = $clog2(N_CHIRP);
    localparam int IN_W  = $clog2(N_SAMP + 1);
    localparam int RES_W = $clog2(N_SAMP + TAPS);
    localparam int FL_W  = $clog2(TAPS + 1);
    localparam int IF_W  = $clog2(N_SAMP + TAPS) + 1;

    localparam logic [IN_W-1:0]  IN_LAST   = IN_W'(N_SAMP - 1);
    localparam logic [RES_W-1:0] RES_FIRST = RES_W'(TAPS - 1);
    localparam logic [RES_W-1:0] RES_LAST  = RES_W'(N_SAMP + TAPS - 2);
    localparam logic [RES_W-1:0] RES_END   = RES_W'(N_SAMP + TAPS - 1);
    localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(TAPS - 1);
    localparam logic [CI_W-1:0]  CI_LAST   = CI_W'(N_CHIRP - 1);

    state_t            state, state_nxt;
    logic [IN_W-1:0]   in_cnt;
    logic [RES_W-1:0]  res_cnt;
    logic [FL_W-1:0]   flush_cnt;
    logic [IF_W-1:0]   inflight;
    logic              eop_done;

    logic abort_hit, take, flush_done, inject, fwd_window, fwd, last_res;
    logic chirp_end, last_chirp, chirp_go, dec;

    always_comb begin
        abort_hit  = abort && (state == ST_WAIT_CHIRP || state == ST_RUN || state == ST_DRAIN);
        take       = (state == ST_RUN) && adc_valid && !abort;
        flush_done = (flush_cnt == FL_LAST);
        inject     = (state == ST_DRAIN || state == ST_ABORT) && !flush_done && !abort_hit;
        fwd_window = (state == ST_RUN || state == ST_DRAIN) && fir_valid && !abort;
        fwd        = fwd_window && (res_cnt >= RES_FIRST) && (res_cnt < RES_END);
        last_res   = fwd && (res_cnt == RES_LAST);
        chirp_end  = (state == ST_DRAIN) && flush_done && eop_done && !abort;
        last_chirp = (chirp_idx == CI_LAST);
        chirp_go   = (state == ST_WAIT_CHIRP) && chirp_start && !abort;
        // A result can only be retired against a pulse already issued or issuing now.
        dec        = fir_valid && (inflight != '0 || fir_ready);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:       if (start) state_nxt = ST_WAIT_CHIRP;
            ST_WAIT_CHIRP: if (abort) state_nxt = ST_ABORT;
                           else if (chirp_start) state_nxt = ST_RUN;
            ST_RUN:        if (abort) state_nxt = ST_ABORT;
                           else if (take && in_cnt == IN_LAST) state_nxt = ST_DRAIN;
            ST_DRAIN:      if (abort) state_nxt = ST_ABORT;
                           else if (chirp_end) state_nxt = last_chirp ? ST_IDLE : ST_WAIT_CHIRP;
            ST_ABORT:      if (flush_done && !fir_ready && inflight == '0) state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            fir_ready    <= 1'b0;
            fir_mix_data <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            frame_done   <= 1'b0;
            chirp_idx    <= '0;
            overrun      <= 1'b0;
            in_cnt       <= '0;
            res_cnt      <= '0;
            flush_cnt    <= '0;
            inflight     <= '0;
            eop_done     <= 1'b0;
        end else begin
            state        <= state_nxt;
            fir_ready    <= take || inject;
            fir_mix_data <= take ? adc_data : '0;
            out_valid    <= fwd;
            out_data     <= fwd ? fir_data : '0;
            out_sop      <= fwd && (res_cnt == RES_FIRST);
            out_eop      <= last_res;
            frame_done   <= chirp_end && last_chirp;
            inflight     <= inflight + IF_W'(fir_ready) - IF_W'(dec);

            if (chirp_go) begin
                in_cnt   <= '0;
                res_cnt  <= '0;
                eop_done <= 1'b0;
            end else begin
                if (take)
                    in_cnt <= in_cnt + 1'b1;
                if (fwd_window && res_cnt < RES_END)
                    res_cnt <= res_cnt + 1'b1;
                if (last_res)
                    eop_done <= 1'b1;
            end

            // Every entry into a flushing state restarts the zero-injection count.
            if (state_nxt != state && (state_nxt == ST_DRAIN || state_nxt == ST_ABORT))
                flush_cnt <= '0;
            else if (inject)
                flush_cnt <= flush_cnt + 1'b1;

            if (state == ST_IDLE && start) begin
                chirp_idx <= '0;
                overrun   <= 1'b0;
            end else begin
                if (chirp_end && !last_chirp)
                    chirp_idx <= chirp_idx + 1'b1;
                if (adc_valid && !abort && (state == ST_WAIT_CHIRP || state == ST_DRAIN))
                    overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_chirp_scheduler.sv
// Directed bench: 16-tap FIR model (taps 1..16, 4-cycle latency) behind the scheduler, two-chirp frames.
module tb_fir_chirp_scheduler;

    localparam int DW = 16;
    localparam int OW = 28;
    localparam int TP = 16;
    localparam int NS = 256;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          chirp_start = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          fir_ready;
    logic [DW-1:0] fir_mix_data;
    logic          fir_valid = 1'b0;
    logic [OW-1:0] fir_data = '0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [$clog2(NC)-1:0] chirp_idx;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    fir_chirp_scheduler #(
        .DATA_W(DW), .OUT_W(OW), .TAPS(TP), .N_SAMP(NS), .N_CHIRP(NC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chirp_start(chirp_start),
        .adc_valid(adc_valid), .adc_data(adc_data), .fir_ready(fir_ready),
        .fir_mix_data(fir_mix_data), .fir_valid(fir_valid), .fir_data(fir_data),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .chirp_idx(chirp_idx), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // FIR model: history is never cleared, like the real filter.
    logic signed [DW-1:0] hist [TP];
    logic [2:0]           vpipe = '0;
    logic [OW-1:0]        dpipe [3];
    int                   acc;

    initial for (int k = 0; k < TP; k++) hist[k] = '0;

    always @(posedge clk) begin
        acc = 0;
        if (fir_ready) begin
            for (int k = TP - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = fir_mix_data;
            for (int k = 0; k < TP; k++) acc += (k + 1) * int'(hist[k]);
        end
        vpipe    <= {vpipe[1:0], fir_ready};
        dpipe[0] <= OW'(acc);
        dpipe[1] <= dpipe[0];
        dpipe[2] <= dpipe[1];
        fir_valid <= vpipe[2];
        fir_data  <= dpipe[2];
    end

    // Monitor: free-running counters; the stimulus takes snapshots and compares deltas.
    int cyc = 0, rdy_n = 0, zero_n = 0, out_n = 0, sop_pos = -1, eop_pos = -1;
    int eop_n = 0, eop_cyc = 0, fd_n = 0, fd_cyc = 0;
    logic signed [OW-1:0] obuf [2048];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fir_ready) begin
            rdy_n++;
            if (fir_mix_data == '0) zero_n++;
        end
        if (out_valid) begin
            if (out_n < 2048) obuf[out_n] = out_data;
            if (out_sop) sop_pos = out_n;
            if (out_eop) begin
                eop_pos = out_n;
                eop_n++;
                eop_cyc = cyc;
            end
            out_n++;
        end
        if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
    end

    int n_chk = 0, n_err = 0;
    int b_rdy, b_zero, b_out;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_chirp();
        chirp_start = 1'b1; tick(); chirp_start = 1'b0;
    endtask

    task automatic snap();
        b_rdy = rdy_n; b_zero = zero_n; b_out = out_n;
    endtask

    // mode 0: constant val every sample; mode 1: impulse of val at sample 0
    task automatic send(input int cnt, input int mode, input int val);
        for (int i = 0; i < cnt; i++) begin
            adc_valid = 1'b1;
            adc_data  = (mode == 0 || i == 0) ? DW'(val) : '0;
            tick();
        end
        adc_valid = 1'b0;
        adc_data  = '0;
    endtask

    task automatic wait_eop(input int target);
        int n = 0;
        while (eop_n < target && n < 3000) begin tick(); n++; end
        if (eop_n < target) chk("eop_timeout", eop_n, target);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin tick(); n++; end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_fir_ready", fir_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_chirp_idx", chirp_idx, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Frame 1, chirp 0: constant 100
        pulse_start();
        chk("f1_busy", busy, 1);
        chk("f1_idx0", chirp_idx, 0);
        snap();
        pulse_chirp();
        send(NS, 0, 100);
        wait_eop(1);
        repeat (4) tick();
        chk("c0_ready_cnt", rdy_n - b_rdy, 271);
        chk("c0_zero_cnt", zero_n - b_zero, 15);
        chk("c0_out_cnt", out_n - b_out, 256);
        chk("c0_sop_pos", sop_pos - b_out, 0);
        chk("c0_eop_pos", eop_pos - b_out, 255);
        chk("c0_out0", obuf[b_out], 13600);
        chk("c0_out241", obuf[b_out + 241], 13500);
        chk("c0_out250", obuf[b_out + 250], 8100);
        chk("c0_out255", obuf[b_out + 255], 1600);
        chk("c0_idx1", chirp_idx, 1);
        chk("c0_busy", busy, 1);
        chk("c0_no_frame_done", fd_n, 0);
        chk("c0_no_overrun", overrun, 0);

        // Frame 1, chirp 1: impulse, plus a stray sample during DRAIN
        snap();
        pulse_chirp();
        send(NS, 1, 1);
        adc_valid = 1'b1; adc_data = DW'(77); tick();
        adc_valid = 1'b0; adc_data = '0;
        wait_eop(2);
        repeat (4) tick();
        chk("c1_ready_cnt", rdy_n - b_rdy, 271);
        chk("c1_out_cnt", out_n - b_out, 256);
        chk("c1_out0", obuf[b_out], 16);
        chk("c1_out1", obuf[b_out + 1], 0);
        chk("c1_out255", obuf[b_out + 255], 0);
        chk("c1_overrun", overrun, 1);
        chk("frame_done_cnt", fd_n, 1);
        chk("frame_done_lag", fd_cyc - eop_cyc, 1);
        chk("f1_idle", busy, 0);

        // Frame 2: abort after the 100th sample
        pulse_start();
        chk("f2_overrun_clr", overrun, 0);
        chk("f2_idx0", chirp_idx, 0);
        pulse_chirp();
        send(100, 0, 100);
        b_zero = zero_n;
        abort = 1'b1; tick(); abort = 1'b0;
        b_out = out_n;
        chk("abort_busy", busy, 1);
        wait_idle();
        chk("abort_no_out", out_n - b_out, 0);
        chk("abort_zeros", zero_n - b_zero, 15);
        chk("abort_no_frame_done", fd_n, 1);

        // Frame 3: clean chirp with negative samples
        pulse_start();
        snap();
        pulse_chirp();
        send(NS, 0, -3);
        wait_eop(3);
        repeat (4) tick();
        chk("f3_out_cnt", out_n - b_out, 256);
        chk("f3_out0", obuf[b_out], -408);
        chk("f3_out255", obuf[b_out + 255], -48);
        chk("f3_idx1", chirp_idx, 1);

        // start and abort together while waiting for a chirp
        b_zero = zero_n;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 1);
        wait_idle();
        chk("sa_zeros", zero_n - b_zero, 15);
        chk("sa_no_frame_done", fd_n, 1);

        // Reset in the middle of RUN
        pulse_start();
        pulse_chirp();
        adc_valid = 1'b1; adc_data = DW'(5);
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_fir_ready", fir_ready, 0);
        chk("mrst_mix_data", fir_mix_data, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_busy", busy, 0);
        adc_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fir_chirp_scheduler.md
FIR_CHIRP_SCHEDULER -- requirements
Module: fir_chirp_scheduler

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, sample width; OUT_W, default 28, filter output width; TAPS, default 16, filter length; N_SAMP, default 256, samples per chirp; N_CHIRP, default 64, chirps per frame.
REQ-002 Ports SHALL be: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 start in 1, one-cycle frame start; abort in 1, one-cycle frame abort; chirp_start in 1, one-cycle chirp ramp start.
REQ-004 adc_valid in 1, sample strobe; adc_data in DATA_W, signed mixer sample.
REQ-005 fir_ready out 1, filter input strobe; fir_mix_data out DATA_W, filter input sample.
REQ-006 fir_valid in 1, filter output strobe; fir_data in OUT_W, signed filter output.
REQ-007 out_valid out 1; out_data out OUT_W; out_sop out 1; out_eop out 1; chirp_idx out clog2(N_CHIRP); busy out 1; frame_done out 1; overrun out 1, sticky.

Function
REQ-008 States SHALL be IDLE, WAIT_CHIRP, RUN, DRAIN, ABORT.
REQ-009 IDLE: start -> WAIT_CHIRP, chirp_idx=0, overrun cleared; start is ignored in every other state.
REQ-010 WAIT_CHIRP: chirp_start -> RUN, input and output counters cleared.
REQ-011 RUN: each adc_valid SHALL produce fir_ready=1 and fir_mix_data=adc_data exactly 1 cycle later (registered); adc_valid may be high every cycle.
REQ-012 RUN: on the N_SAMP-th accepted sample -> DRAIN.
REQ-013 DRAIN: one fir_ready per cycle with fir_mix_data=0 for TAPS-1 consecutive cycles, then no further fir_ready.
REQ-014 Each chirp SHALL issue N_SAMP+TAPS-1 fir_ready pulses; the first TAPS-1 fir_valid results of the chirp SHALL be discarded, and the next N_SAMP forwarded.
REQ-015 Forwarding SHALL be registered: out_valid/out_data 1 cycle after fir_valid/fir_data; out_sop on the 1st forwarded result and out_eop on the N_SAMP-th.
REQ-016 Chirp completion (out_eop issued and all TAPS-1 flush samples sent): chirp_idx<N_CHIRP-1 -> chirp_idx+1, WAIT_CHIRP; else frame_done one-cycle pulse with the final out_eop+1 cycle, -> IDLE.
REQ-017 adc_valid outside RUN SHALL be dropped with no fir_ready; if in DRAIN or WAIT_CHIRP, overrun SHALL set until next start.
REQ-018 chirp_start outside WAIT_CHIRP SHALL be ignored.
REQ-019 The block SHALL keep an in-flight count = fir_ready pulses issued minus fir_valid received, width clog2(N_SAMP+TAPS)+1; it SHALL never go negative.
REQ-020 abort in WAIT_CHIRP/RUN/DRAIN -> ABORT next cycle; abort in IDLE or ABORT has no effect; abort has priority over every same-cycle event.
REQ-021 ABORT: inject TAPS-1 zero samples (one per cycle), suppress all out_valid/sop/eop, discard every fir_valid; -> IDLE when injection done and in-flight count is 0; frame_done SHALL NOT pulse.
REQ-022 fir_valid in IDLE SHALL be ignored and not forwarded.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 On rst_n low all outputs SHALL be 0, state IDLE, and all counters and overrun 0.
REQ-025 Reset mid-chirp SHALL abandon the frame without flush; filter history is not cleared, and this is accepted.

Structure
REQ-026 State encoding, TAPS, N_SAMP and N_CHIRP defaults, and widths DATA_W/OUT_W SHALL live in shared package fmcw_pkg.
REQ-027 The block is single-module; the FIR filter is instantiated by the parent, and no sub-module is required.

Verification
REQ-028 start, chirp_start, then 256 back-to-back samples of value 100 -> 271 fir_ready pulses (256 data, 15 zero), 256 out_valid, sop on 1st, eop on 256th.
REQ-029 N_CHIRP=2, two full chirps -> chirp_idx 0 then 1; frame_done pulses once, 1 cycle after the second eop; busy 0 afterwards.
REQ-030 Impulse: sample0=1, rest 0, with a 4-cycle-latency filter model -> forwarded results equal the taps in order beyond index 15; no data from the prior chirp leaks into the next.
REQ-031 abort after the 100th sample -> ABORT, 15 zeros injected, no out_valid, IDLE once in-flight reaches 0; a new start then runs a clean frame.
REQ-032 adc_valid during DRAIN -> sample dropped, overrun=1, output count still 256; overrun cleared on the next start.
REQ-033 start and abort in the same cycle from WAIT_CHIRP -> ABORT; rst_n asserted mid-RUN -> all outputs 0 immediately.
